// File: rtl/bytebeat_voice_mixer_if.sv
// Sample handshake bundle between the bytebeat generators and the mixer.
// One valid/ready pair per voice, samples packed voice-major.
interface bytebeat_voice_mixer_if #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 8
);
    logic [NUM_CH*SAMPLE_W-1:0] pcm_data;
    logic [NUM_CH-1:0]          pcm_vld;
    logic [NUM_CH-1:0]          pcm_rdy;

    modport master (
        output pcm_data,
        output pcm_vld,
        input  pcm_rdy
    );

    modport slave (
        input  pcm_data,
        input  pcm_vld,
        output pcm_rdy
    );
endinterface

// File: rtl/bytebeat_voice_mixer.sv
// Multi-voice bytebeat back end: sample-rate tick, per-voice capture,
// averaged mix and glitch-free PWM for each voice and the mix.
module bytebeat_voice_mixer #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 8,
    parameter int DIV_W    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIV_W-1:0]    div,
    input  logic [NUM_CH-1:0]   ch_en,
    bytebeat_voice_mixer_if.slave pcm,
    input  logic                underrun_clr,
    output logic                tick,
    output logic [NUM_CH-1:0]   underrun,
    output logic [SAMPLE_W-1:0] mix_out,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                pwm_mix
);
    localparam int LG    = $clog2(NUM_CH);
    localparam int SUM_W = SAMPLE_W + LG;

    logic [DIV_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] hold [NUM_CH];
    logic [SAMPLE_W-1:0] duty [NUM_CH];
    logic [SAMPLE_W-1:0] duty_mix;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [SAMPLE_W-1:0] mix_q;
    logic                mix_upd;
    logic [NUM_CH-1:0]   ur_q;
    logic [NUM_CH-1:0]   ur_set;
    logic [NUM_CH-1:0]   pwm_q;
    logic                pwm_mix_q;
    logic [SUM_W-1:0]    sum;
    logic                tick_c;

    // Gated by rst_n so no strobe escapes while reset is held.
    assign tick_c = rst_n & (cnt >= div);
    assign tick   = tick_c;

    assign pcm.pcm_rdy = {NUM_CH{tick_c}};
    assign underrun    = ur_q;
    assign mix_out     = mix_q;
    assign pwm_out     = pwm_q;
    assign pwm_mix     = pwm_mix_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt >= div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
        end else if (tick_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pcm.pcm_vld[i]) begin
                    hold[i] <= pcm.pcm_data[i*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    end

    always_comb begin
        ur_set = '0;
        if (tick_c) begin
            ur_set = ch_en & ~pcm.pcm_vld;
        end
    end

    // A set in the same cycle as a clear must survive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ur_q <= '0;
        end else begin
            ur_q <= (ur_q & ~{NUM_CH{underrun_clr}}) | ur_set;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_en[i]) begin
                sum = sum + SUM_W'(hold[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_upd <= 1'b0;
            mix_q   <= '0;
        end else begin
            mix_upd <= tick_c;
            if (mix_upd) begin
                mix_q <= SAMPLE_W'(sum >> LG);
            end
        end
    end

    // Duty reloads only on the wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            duty_mix <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty[i] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                duty_mix <= mix_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty[i] <= hold[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q     <= '0;
            pwm_mix_q <= 1'b0;
        end else begin
            pwm_mix_q <= (pwm_cnt < duty_mix);
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= (pwm_cnt < duty[i]);
            end
        end
    end
endmodule
